// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM fade sequencer: register map, FSM states,
// reset defaults and the saturating per-channel fade step.
package pwm_ctrl_pkg;

    localparam logic [7:0] ADDR_CH_FIRST = 8'h01;
    localparam logic [7:0] ADDR_STEP     = 8'h08;
    localparam logic [7:0] ADDR_RATE     = 8'h09;
    localparam logic [7:0] ADDR_ALL_OFF  = 8'hFF;

    localparam logic [7:0] STEP_RESET = 8'h01;
    localparam logic [7:0] RATE_RESET = 8'h00;

    typedef enum logic {
        IDLE,
        SWEEP
    } fade_state_t;

    // Move cur toward tgt by step, landing exactly on tgt instead of overshooting.
    function automatic logic [7:0] fade_next(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] diff;
        fade_next = cur;
        diff      = '0;
        if (step == '0) begin
            fade_next = tgt;
        end else if (cur < tgt) begin
            diff      = {1'b0, tgt} - {1'b0, cur};
            fade_next = (diff <= {1'b0, step}) ? tgt : cur + step;
        end else if (cur > tgt) begin
            diff      = {1'b0, cur} - {1'b0, tgt};
            fade_next = (diff <= {1'b0, step}) ? tgt : cur - step;
        end
    endfunction

endpackage

// File: rtl/pwm_fade_tick.sv
// Fade tick generator: prescaler of TICK_DIV cycles followed by a rate divider,
// giving one single-cycle tick every (rate+1)*TICK_DIV cycles.
module pwm_fade_tick #(
    parameter int TICK_DIV = 6000,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rate,
    input  logic       i_clear,
    output logic       o_tick
);

    logic [DIV_W-1:0] r_presc;
    logic [7:0]       r_rate_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_presc == DIV_W'(TICK_DIV - 1));
    assign o_tick = r_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_rate_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (i_clear) begin
            r_presc    <= '0;
            r_rate_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_wrap) begin
                r_presc <= '0;
                if (r_rate_cnt == i_rate) begin
                    r_rate_cnt <= '0;
                    r_tick     <= 1'b1;
                end else begin
                    r_rate_cnt <= r_rate_cnt + 8'd1;
                end
            end else begin
                r_presc <= r_presc + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Per-channel target/current duty registers written from the SPI decode; each
// fade tick sweeps the channels one per cycle, ramping current toward target.
module pwm_fade_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int TICK_DIV = 6000,
    parameter int DIV_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic [8*NUM_CH-1:0]   duty_out,
    output logic                  busy,
    output logic                  settled
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [7:0]      r_tgt [NUM_CH];
    logic [7:0]      r_cur [NUM_CH];
    logic [7:0]      r_step;
    logic [7:0]      r_rate;
    logic            r_wr_q;
    logic            r_settled;
    fade_state_t     r_state;
    logic [CH_W-1:0] r_idx;

    logic            w_accept;
    logic            w_all_off;
    logic            w_tgt_wr;
    logic [CH_W-1:0] w_wr_idx;
    logic            w_tick;
    logic            w_all_eq;

    // wr_valid_q resets high so a level held through reset release is not a write.
    assign w_accept  = wr_valid & ~r_wr_q;
    assign w_all_off = w_accept && (wr_addr == ADDR_ALL_OFF);
    assign w_tgt_wr  = w_accept && (wr_addr >= ADDR_CH_FIRST) && (wr_addr <= 8'(NUM_CH));
    assign w_wr_idx  = CH_W'(wr_addr - ADDR_CH_FIRST);

    pwm_fade_tick #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_rate  (r_rate),
        .i_clear (w_all_off),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_all_eq = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_cur[i] != r_tgt[i]) begin
                w_all_eq = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= '0;
                r_cur[i] <= '0;
            end
            r_step    <= STEP_RESET;
            r_rate    <= RATE_RESET;
            r_wr_q    <= 1'b1;
            r_settled <= 1'b1;
            r_state   <= IDLE;
            r_idx     <= '0;
        end else begin
            r_wr_q    <= wr_valid;
            r_settled <= w_all_eq;
            // All-off overrides both register writes and the sweep update.
            if (w_all_off) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    r_tgt[i] <= '0;
                    r_cur[i] <= '0;
                end
                r_state <= IDLE;
                r_idx   <= '0;
            end else begin
                if (w_accept) begin
                    case (wr_addr)
                        ADDR_STEP: r_step <= wr_data;
                        ADDR_RATE: r_rate <= wr_data;
                        default: begin
                            if (w_tgt_wr) begin
                                r_tgt[w_wr_idx] <= wr_data;
                            end
                        end
                    endcase
                end
                case (r_state)
                    IDLE: begin
                        if (w_tick) begin
                            r_state <= SWEEP;
                            r_idx   <= '0;
                        end
                    end
                    SWEEP: begin
                        r_cur[r_idx] <= fade_next(r_cur[r_idx], r_tgt[r_idx], r_step);
                        if (r_idx == CH_W'(NUM_CH - 1)) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + CH_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        duty_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            duty_out[8*i +: 8] = r_cur[i];
        end
    end

    assign busy    = (r_state == SWEEP);
    assign settled = r_settled;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: cycle-level reference model
// compared every cycle, plus directed checks with hand-computed values.
module tb_pwm_fade_sequencer;

    localparam int NCH = 7;
    localparam int TD  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wr_valid;
    logic [7:0]           wr_addr;
    logic [7:0]           wr_data;
    logic [8*NCH-1:0]     duty_out;
    logic                 busy;
    logic                 settled;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pwm_fade_sequencer #(
        .NUM_CH   (NCH),
        .TICK_DIV (TD),
        .DIV_W    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .duty_out (duty_out),
        .busy     (busy),
        .settled  (settled)
    );

    always #5 clk = ~clk;

    // Reference model. m_cnt counts clock edges since reset/all-off, so the
    // prescaler wraps on edges where m_cnt % TD == TD-1. A tick decided on edge
    // m_fire makes channel k update on edge m_fire+1+k.
    int m_tgt [1:NCH];
    int m_cur [1:NCH];
    int m_step, m_rate, m_wraps, m_cnt, m_fire;
    bit m_wrq, m_settled;
    int mj, mk;
    bit macc, meq;

    function automatic int fade(int c, int t, int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 1; i <= NCH; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
        end
        m_step = 1; m_rate = 0; m_wraps = 0; m_cnt = 0; m_fire = -1000;
        m_wrq = 1'b1; m_settled = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_reset();
        end else begin
            mj   = m_cnt;
            macc = wr_valid && !m_wrq;
            m_wrq = wr_valid;
            meq = 1'b1;
            for (int i = 1; i <= NCH; i++) if (m_cur[i] != m_tgt[i]) meq = 1'b0;
            mk = mj - m_fire - 1;
            if (mk >= 1 && mk <= NCH) m_cur[mk] = fade(m_cur[mk], m_tgt[mk], m_step);
            if (mj % TD == TD - 1) begin
                if (m_wraps == m_rate) begin
                    m_wraps = 0;
                    if (!(mk + 1 >= 1 && mk + 1 <= NCH)) m_fire = mj;
                end else begin
                    m_wraps = (m_wraps + 1) % 256;
                end
            end
            m_cnt = mj + 1;
            if (macc) begin
                if (wr_addr >= 1 && wr_addr <= NCH) m_tgt[wr_addr] = wr_data;
                else if (wr_addr == 8'h08) m_step = wr_data;
                else if (wr_addr == 8'h09) m_rate = wr_data;
                else if (wr_addr == 8'hFF) begin
                    for (int i = 1; i <= NCH; i++) begin
                        m_tgt[i] = 0;
                        m_cur[i] = 0;
                    end
                    m_cnt = 0; m_wraps = 0; m_fire = -1000;
                end
            end
            m_settled = meq;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [8*NCH-1:0] exp_duty;
    int               exp_d;
    always @(negedge clk) begin
        if (!reset) begin
            exp_duty = '0;
            for (int i = 1; i <= NCH; i++) exp_duty[8*(i-1) +: 8] = 8'(m_cur[i]);
            exp_d = m_cnt - 1 - m_fire;
            check("model_duty", 64'(duty_out), 64'(exp_duty));
            check("model_busy", 64'(busy), 64'((exp_d >= 1 && exp_d <= NCH) ? 1 : 0));
            check("model_settled", 64'(settled), 64'(m_settled));
        end
    end

    function automatic logic [7:0] ch(int k);
        return duty_out[8*k-1 -: 8];
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_busy(output int rise);
        rise = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) begin
                rise = cyc;
                break;
            end
        end
        if (rise < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL busy_timeout: got no busy expected busy within 400 cycles");
            rise = cyc;
        end
    endtask

    task automatic wait_sweep(output int rise, output int len);
        wait_busy(rise);
        len = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) len++;
            else break;
        end
    endtask

    logic [7:0] seq_up [4] = '{8'h40, 8'h80, 8'hC0, 8'hFF};
    logic [7:0] seq_dn [4] = '{8'hBF, 8'h7F, 8'h3F, 8'h05};

    initial begin
        int r, r0, r1, len, c0;
        reset = 1'b1; wr_valid = 1'b1; wr_addr = 8'h03; wr_data = 8'h55;

        // 1: wr_valid high through reset release must not write
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        check("t1_duty", 64'(duty_out), 64'h0);
        check("t1_settled", 64'(settled), 64'h1);
        check("t1_busy", 64'(busy), 64'h0);

        // 2: step 1 ramp on channel 3
        wait_sweep(r, len);
        wr(8'h03, 8'h10);
        for (int i = 1; i <= 16; i++) begin
            wait_sweep(r, len);
            check("t2_ch3", 64'(ch(3)), 64'(i));
        end
        check("t2_others", 64'(duty_out), 64'h0000_0000_0010_0000);
        check("t2_settled", 64'(settled), 64'h1);

        // 3: large step clamps at 0xFF, 7-cycle busy
        wait_sweep(r, len);
        wr(8'h08, 8'h40);
        wr(8'h01, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            wait_sweep(r, len);
            check("t3_ch1", 64'(ch(1)), 64'(seq_up[i]));
            check("t3_busy_len", 64'(len), 64'd7);
        end

        // 4: ramp down with clamp, then rate=2 spacing
        wr(8'h02, 8'hFF);
        for (int i = 0; i < 4; i++) wait_sweep(r, len);
        check("t4_ch2_top", 64'(ch(2)), 64'hFF);
        wr(8'h02, 8'h05);
        for (int i = 0; i < 4; i++) begin
            wait_sweep(r, len);
            check("t4_ch2", 64'(ch(2)), 64'(seq_dn[i]));
        end
        wr(8'h09, 8'h02);
        wait_sweep(r0, len);
        wait_sweep(r1, len);
        check("t4_spacing", 64'(r1 - r0), 64'd48);
        wait_sweep(r, len);
        check("t4_spacing2", 64'(r - r1), 64'd48);

        // 5: all-off mid-sweep, prescaler restarts
        wait_busy(r);
        wr_valid = 1'b1; wr_addr = 8'hFF; wr_data = 8'h00;
        @(negedge clk);
        wr_valid = 1'b0;
        check("t5_duty", 64'(duty_out), 64'h0);
        check("t5_busy", 64'(busy), 64'h0);
        c0 = cyc;
        wait_busy(r);
        check("t5_restart", 64'(r - c0), 64'd49);
        wr(8'h09, 8'h00);

        // 6: step 0 jumps, ch7 lands 7 edges after busy rises; ignored addresses
        wait_sweep(r, len);
        wr(8'h08, 8'h00);
        wr(8'h07, 8'h80);
        wait_busy(r);
        repeat (6) @(negedge clk);
        check("t6_ch7_before", 64'(ch(7)), 64'h00);
        @(negedge clk);
        check("t6_ch7_after", 64'(ch(7)), 64'h80);
        wr(8'h00, 8'h33);
        wr(8'h0A, 8'h44);
        repeat (20) @(negedge clk);
        check("t6_ignored", 64'(duty_out), 64'h0080_0000_0000_0000);
        check("t6_settled", 64'(settled), 64'h1);

        // 7: reset mid-sweep
        wr(8'h01, 8'h20);
        wait_busy(r);
        #2 reset = 1'b1;
        #1;
        check("t7_duty", 64'(duty_out), 64'h0);
        check("t7_busy", 64'(busy), 64'h0);
        check("t7_settled", 64'(settled), 64'h1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
